// File: rtl/writeback_queue_9b.sv
// Write-back queue feeding the 9-bit register bank: FIFO of {addr,data} requests
// retired one per cycle into a registered one-hot strobe. Optional forwarding: WBQ_FWD_EN.
module writeback_queue_9b #(
    parameter int DEPTH = 4,
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_addr,
    input  logic [DW-1:0]    in_data,
    input  logic             hold,
    input  logic             flush,
    output logic [NREGS-1:0] chosen,
    output logic             w_en,
    output logic [DW-1:0]    w_data,
    output logic [AW:0]      count,
    output logic             err,
    input  logic [AW-1:0]    fwd_addr,
    output logic             fwd_hit,
    output logic [DW-1:0]    fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [AW:0] NREGS_LIM = (AW+1)'(NREGS);
    localparam logic [PW:0] PTR_ONE   = (PW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   occ;
    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];

    logic             empty;
    logic             full;
    logic             addr_ok;
    logic             take;
    logic             push;
    logic             pop;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;
    logic [NREGS-1:0] head_onehot;

    assign occ   = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign count = (AW+1)'(occ);

    // Handshake: a request transfers on any rising edge where in_valid && in_ready.
    // in_ready depends only on fullness, never on in_valid. A transferred request with
    // an out-of-range address is dropped and raises err; flush discards any transfer.
    assign in_ready = !full;
    assign addr_ok  = ({1'b0, in_addr} < NREGS_LIM);
    assign take     = in_valid && in_ready;
    assign push     = take && addr_ok && !flush;
    assign pop      = !empty && !hold && !flush;

    assign head_addr = mem_addr[rd_ptr[PW-1:0]];
    assign head_data = mem_data[rd_ptr[PW-1:0]];

    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            head_onehot[i] = (head_addr == AW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr[PW-1:0]] <= in_addr;
            mem_data[wr_ptr[PW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chosen <= '0;
            w_en   <= 1'b0;
            w_data <= '0;
        end else if (pop) begin
            chosen <= head_onehot;
            w_en   <= 1'b1;
            w_data <= head_data;
        end else begin
            chosen <= '0;
            w_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (take && !addr_ok) begin
            err <= 1'b1;
        end
    end

`ifdef WBQ_FWD_EN
    logic          fwd_hit_c;
    logic [DW-1:0] fwd_data_c;
    logic [PW-1:0] fwd_idx;

    // Scan oldest to newest so the newest match overwrites older ones; the output
    // stage is older than every FIFO entry.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        fwd_idx    = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (w_en && chosen[i] && (fwd_addr == AW'(i))) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = w_data;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr[PW-1:0] + PW'(k);
            if (((PW+1)'(k) < occ) && (mem_addr[fwd_idx] == fwd_addr)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = mem_data[fwd_idx];
            end
        end
    end

    assign fwd_hit  = fwd_hit_c;
    assign fwd_data = fwd_data_c;
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_writeback_queue_9b.sv
// Directed bench for writeback_queue_9b: an 8-register instance plus a 6-register
// instance (for illegal-address checks) driven by the same stimulus.
module tb_writeback_queue_9b;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic [2:0] in_addr;
    logic [8:0] in_data;
    logic       hold;
    logic       flush;
    logic [2:0] fwd_addr;

    logic       in_ready, w_en, err, fwd_hit;
    logic [7:0] chosen;
    logic [8:0] w_data, fwd_data;
    logic [3:0] count;

    logic       in_ready6, w_en6, err6, fwd_hit6;
    logic [5:0] chosen6;
    logic [8:0] w_data6, fwd_data6;
    logic [3:0] count6;

    writeback_queue_9b dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .hold(hold), .flush(flush),
        .chosen(chosen), .w_en(w_en), .w_data(w_data), .count(count), .err(err),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    writeback_queue_9b #(.NREGS(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
        .in_addr(in_addr), .in_data(in_data), .hold(hold), .flush(flush),
        .chosen(chosen6), .w_en(w_en6), .w_data(w_data6), .count(count6), .err(err6),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit6), .fwd_data(fwd_data6)
    );

    int tests = 0;
    int fails = 0;
    logic [11:0] exp_q[$];
    logic [11:0] e;
    logic [7:0]  oh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // clock/reset
        rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        hold = 1'b0; flush = 1'b0; fwd_addr = '0;
        #2;
        chk("rst_chosen", chosen, 0);
        chk("rst_w_en", w_en, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);
        tick; tick;
        rst = 1'b1;
        tick;

        // single write addr 5 -> visible two cycles after handshake
        in_valid = 1'b1; in_addr = 3'd5; in_data = 9'h1A5;
        tick;
        in_valid = 1'b0;
        chk("single_c1_count", count, 1);
        chk("single_c1_w_en", w_en, 0);
        tick;
        chk("single_c2_chosen", chosen, 8'b0010_0000);
        chk("single_c2_w_en", w_en, 1);
        chk("single_c2_w_data", w_data, 9'h1A5);
        chk("single_c2_count", count, 0);
        tick;
        chk("single_c3_w_en", w_en, 0);
        chk("single_c3_chosen", chosen, 0);
        chk("single_c3_w_data_hold", w_data, 9'h1A5);

        // hold burst: fill to 4, 5th waits, then drain in order
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_addr = 3'(i + 1); in_data = 9'(9'h040 + i);
            exp_q.push_back({3'(i + 1), 9'(9'h040 + i)});
            tick;
        end
        chk("hold_full_count", count, 4);
        chk("hold_full_ready", in_ready, 0);
        in_addr = 3'd4; in_data = 9'h0AA;
        tick;
        chk("hold_5th_count", count, 4);
        chk("hold_5th_w_en", w_en, 0);
        exp_q.push_back({3'd4, 9'h0AA});
        hold = 1'b0;
        tick;
        e = exp_q.pop_front(); oh = 8'b1 << e[11:9];
        chk("drain0_w_en", w_en, 1);
        chk("drain0_chosen", chosen, oh);
        chk("drain0_w_data", w_data, e[8:0]);
        chk("drain0_count_blocked", count, 3);
        chk("drain0_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        e = exp_q.pop_front(); oh = 8'b1 << e[11:9];
        chk("drain1_chosen", chosen, oh);
        chk("drain1_w_data", w_data, e[8:0]);
        chk("drain1_count_pushpop", count, 3);
        for (int i = 2; i < 5; i++) begin
            tick;
            e = exp_q.pop_front(); oh = 8'b1 << e[11:9];
            chk("drain_w_en", w_en, 1);
            chk("drain_chosen", chosen, oh);
            chk("drain_w_data", w_data, e[8:0]);
            chk("drain_count", count, 32'(4 - i));
        end
        tick;
        chk("drain_done_w_en", w_en, 0);
        chk("drain_done_chosen", chosen, 0);
        chk("drain_done_err6", err6, 0);

        // illegal address on 6-register instance
        in_valid = 1'b1; in_addr = 3'd7; in_data = 9'h077;
        tick;
        in_valid = 1'b0;
        chk("illegal_err6", err6, 1);
        chk("illegal_count6", count6, 0);
        chk("illegal_count8", count, 1);
        tick;
        chk("illegal_w_en6", w_en6, 0);
        chk("illegal_w_en8", w_en, 1);
        chk("illegal_chosen8", chosen, 8'b1000_0000);
        chk("illegal_err6_sticky", err6, 1);

        // flush with two pending
        hold = 1'b1;
        in_valid = 1'b1; in_addr = 3'd1; in_data = 9'h101;
        tick;
        in_addr = 3'd2; in_data = 9'h102;
        tick;
        in_valid = 1'b0;
        chk("preflush_count", count, 2);
        flush = 1'b1;
        tick;
        flush = 1'b0; hold = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_w_en", w_en, 0);
        chk("flush_err6_kept", err6, 1);
        tick;
        chk("postflush_w_en", w_en, 0);
        chk("postflush_count", count, 0);

        // forwarding lookup
        hold = 1'b1;
        in_valid = 1'b1; in_addr = 3'd2; in_data = 9'h011;
        tick;
        in_data = 9'h022;
        tick;
        in_valid = 1'b0;
        fwd_addr = 3'd2;
        #1;
`ifdef WBQ_FWD_EN
        chk("fwd_hit_r2", fwd_hit, 1);
        chk("fwd_data_r2", fwd_data, 9'h022);
`else
        chk("fwd_off_hit", fwd_hit, 0);
        chk("fwd_off_data", fwd_data, 0);
`endif
        fwd_addr = 3'd3;
        #1;
        chk("fwd_miss_r3", fwd_hit, 0);
        flush = 1'b1;
        tick;
        flush = 1'b0;

        // async reset mid-burst
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_addr = 3'(i + 1); in_data = 9'(9'h0F0 + i);
            tick;
        end
        in_valid = 1'b0;
        chk("burst_count", count, 3);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_w_en", w_en, 0);
        chk("midrst_chosen", chosen, 0);
        chk("midrst_w_data", w_data, 0);
        chk("midrst_err6", err6, 0);
        hold = 1'b0;
        tick; tick;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("postrst_w_en", w_en, 0);
            chk("postrst_count", count, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
